// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C mode codes and readback-checker state encodings
package i2c_pkg;

  // Mode codes driven by the config sequencer on i2c_config
  localparam logic [7:0] I2C_MODE_IDLE      = 8'h00;
  localparam logic [7:0] I2C_MODE_WR_SINGLE = 8'h01;
  localparam logic [7:0] I2C_MODE_WR_DOUBLE = 8'h02;
  localparam logic [7:0] I2C_MODE_WR_PAGE   = 8'h03;
  localparam logic [7:0] I2C_MODE_RD_SINGLE = 8'h04;
  localparam logic [7:0] I2C_MODE_RD_DOUBLE = 8'h05;
  localparam logic [7:0] I2C_MODE_RD_PAGE   = 8'h06;

  // Readback checker states; the numeric values are visible on chk_state
  typedef enum logic [2:0] {
    CHK_IDLE    = 3'd0,
    CHK_WR_WAIT = 3'd1,
    CHK_RD_ARM  = 3'd2,
    CHK_RD_WAIT = 3'd3,
    CHK_SETTLE  = 3'd4,
    CHK_SAMPLE  = 3'd5,
    CHK_DONE    = 3'd6
  } chk_state_e;

endpackage

// File: rtl/i2c_readback_checker_if.sv
// rtl/i2c_readback_checker_if.sv - monitored I2C signals and checker results
interface i2c_readback_checker_if;
  logic [7:0]  i2c_config;
  logic [7:0]  i2c_reg_data;
  logic [7:0]  i2c_read_data;
  logic [7:0]  i2c_ack;
  logic        check_done;
  logic        check_pass;
  logic        check_fail;
  logic        timeout_err;
  logic [7:0]  exp_data;
  logic [7:0]  got_data;
  logic [2:0]  chk_state;
  logic [23:0] latency_cyc;

  // Sequencer / master-logic side
  modport master (
    output i2c_config, i2c_reg_data, i2c_read_data, i2c_ack,
    input  check_done, check_pass, check_fail, timeout_err,
           exp_data, got_data, chk_state, latency_cyc
  );

  // Checker side
  modport slave (
    input  i2c_config, i2c_reg_data, i2c_read_data, i2c_ack,
    output check_done, check_pass, check_fail, timeout_err,
           exp_data, got_data, chk_state, latency_cyc
  );
endinterface

// File: rtl/i2c_flag_sync.sv
// rtl/i2c_flag_sync.sv - 2-flop synchroniser with single-cycle rising-edge pulse
module i2c_flag_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic flag_raw,
  output logic flag_rise
);
  logic meta_q, sync_q, prev_q;
  logic meta_d, sync_d, prev_d;

  // Shift the raw flag through two sync stages plus one history stage
  always_comb begin
    meta_d = flag_raw;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Register the sync chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign flag_rise = sync_q & ~prev_q;
endmodule

// File: rtl/i2c_readback_checker.sv
// rtl/i2c_readback_checker.sv - write/readback monitor; optional I2C_CHECK_LATENCY_EN latency counter
module i2c_readback_checker
  import i2c_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 12_000_000,
  parameter int         SETTLE_CYC  = 16,
  parameter logic [7:0] MODE_WR     = I2C_MODE_WR_SINGLE,
  parameter logic [7:0] MODE_RD     = I2C_MODE_RD_SINGLE
) (
  input  logic                    clk_12m,
  input  logic                    rst_n,
  i2c_readback_checker_if.slave   bus
);
  localparam logic [23:0] TMO_LAST    = 24'(TIMEOUT_CYC - 1);
  localparam logic [23:0] SETTLE_LAST = 24'(SETTLE_CYC - 1);
  localparam logic [23:0] SAMPLE_LAST = 24'd7;

  chk_state_e  state_q;
  logic [23:0] tmo_q;
  logic [7:0]  s0_q, exp_q, got_q;
  logic        done_q, pass_q, fail_q, timeout_q;
  logic        done_raw, done_evt;
  logic        samp_match, samp_last;
  logic [7:0]  samp_val;

  assign done_raw = bus.i2c_ack[2] | bus.i2c_ack[5];

  i2c_flag_sync u_done_sync (
    .clk       (clk_12m),
    .rst_n     (rst_n),
    .flag_raw  (done_raw),
    .flag_rise (done_evt)
  );

  // Read data is only trusted once two consecutive samples agree; the first
  // SAMPLE cycle has no valid previous sample so it can never match
  always_comb begin
    samp_match = (tmo_q != 24'd0) && (s0_q == bus.i2c_read_data);
    samp_last  = (tmo_q == SAMPLE_LAST);
    samp_val   = samp_match ? s0_q : bus.i2c_read_data;
  end

  // Checker FSM with registered result flags; tmo doubles as the settle and sample counter
  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CHK_IDLE;
      tmo_q     <= '0;
      s0_q      <= '0;
      exp_q     <= '0;
      got_q     <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        CHK_IDLE: begin
          if (bus.i2c_config == MODE_WR) begin
            exp_q   <= bus.i2c_reg_data;
            tmo_q   <= '0;
            state_q <= CHK_WR_WAIT;
          end
        end
        CHK_WR_WAIT, CHK_RD_WAIT: begin
          if (done_evt) begin
            tmo_q   <= '0;
            state_q <= (state_q == CHK_WR_WAIT) ? CHK_RD_ARM : CHK_SETTLE;
          end else if (tmo_q == TMO_LAST) begin
            tmo_q     <= '0;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            fail_q    <= 1'b1;
            state_q   <= CHK_DONE;
          end else begin
            tmo_q <= tmo_q + 24'd1;
          end
        end
        CHK_RD_ARM: begin
          if (bus.i2c_config == MODE_RD) begin
            tmo_q   <= '0;
            state_q <= CHK_RD_WAIT;
          end
        end
        CHK_SETTLE: begin
          if (tmo_q == SETTLE_LAST) begin
            tmo_q   <= '0;
            state_q <= CHK_SAMPLE;
          end else begin
            tmo_q <= tmo_q + 24'd1;
          end
        end
        CHK_SAMPLE: begin
          s0_q <= bus.i2c_read_data;
          if (samp_match || samp_last) begin
            got_q   <= samp_val;
            done_q  <= 1'b1;
            pass_q  <= (samp_val == exp_q);
            fail_q  <= (samp_val != exp_q);
            tmo_q   <= '0;
            state_q <= CHK_DONE;
          end else begin
            tmo_q <= tmo_q + 24'd1;
          end
        end
        CHK_DONE: begin
          state_q <= CHK_DONE;
        end
        default: begin
          state_q <= CHK_IDLE;
        end
      endcase
    end
  end

`ifdef I2C_CHECK_LATENCY_EN
  logic [23:0] lat_q, lat_d;

  // Count cycles from leaving IDLE until DONE, saturating at all-ones
  always_comb begin
    lat_d = lat_q;
    if (state_q == CHK_IDLE) lat_d = '0;
    else if (state_q != CHK_DONE && lat_q != 24'hFFFFFF) lat_d = lat_q + 24'd1;
  end

  // Register the latency count
  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) lat_q <= '0;
    else        lat_q <= lat_d;
  end

  assign bus.latency_cyc = (state_q == CHK_DONE) ? lat_q : 24'd0;
`else
  assign bus.latency_cyc = 24'd0;
`endif

  assign bus.check_done  = done_q;
  assign bus.check_pass  = pass_q;
  assign bus.check_fail  = fail_q;
  assign bus.timeout_err = timeout_q;
  assign bus.exp_data    = exp_q;
  assign bus.got_data    = got_q;
  assign bus.chk_state   = state_q;
endmodule
